// File: rtl/cpu_board_pkg.sv
// Shared encodings for the CPU board front end: debounce states, button bit
// positions and the browse-index width.
package cpu_board_pkg;

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned NUM_BTN = 5;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_MID   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_HI = 2'b01,
        PRESSED = 2'b10,
        WAIT_LO = 2'b11
    } db_state_t;

endpackage

// File: rtl/debounce_fsm.sv
// One push-button: 2-flop synchroniser, stability counter and press/release FSM
// producing a clean level and a single-cycle press pulse.
module debounce_fsm
    import cpu_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MAX = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int unsigned     CNT_W    = (DEBOUNCE_MAX > 1) ? $clog2(DEBOUNCE_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

    logic             sync_meta;
    logic             sync;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             pulse_nxt;

    // Pads are asynchronous to the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sync) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                // A short dip while held is treated as bounce; no new pulse.
                if (sync) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/button_nav.sv
// Board input stage: debounces the five buttons and keeps the 0..IDX_MAX
// data-memory browse index stepped by the left/right press pulses.
module button_nav
    import cpu_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MAX = 1_000_000,
    parameter int unsigned IDX_MAX      = 9
) (
    input  logic               CLK_in,
    input  logic               reset,
    input  logic               button_up,
    input  logic               button_down,
    input  logic               button_left,
    input  logic               button_right,
    input  logic               button_middle,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [IDX_W-1:0]   idx,
    output logic [31:0]        i
);

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(IDX_MAX);

    logic [NUM_BTN-1:0] raw;
    logic [IDX_W-1:0]   idx_nxt;
    logic               step_r;
    logic               step_l;

    always_comb begin
        raw            = '0;
        raw[BTN_UP]    = button_up;
        raw[BTN_DOWN]  = button_down;
        raw[BTN_LEFT]  = button_left;
        raw[BTN_RIGHT] = button_right;
        raw[BTN_MID]   = button_middle;
    end

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        debounce_fsm #(
            .DEBOUNCE_MAX(DEBOUNCE_MAX)
        ) u_db (
            .clk  (CLK_in),
            .rst_n(reset),
            .raw  (raw[b]),
            .level(btn_level[b]),
            .pulse(btn_pulse[b])
        );
    end

    assign step_r = btn_pulse[BTN_RIGHT];
    assign step_l = btn_pulse[BTN_LEFT];

    // Opposing pulses in the same cycle cancel.
    always_comb begin
        idx_nxt = idx;
        if (step_r && !step_l) begin
            idx_nxt = (idx == IDX_TOP) ? '0 : idx + IDX_W'(1);
        end else if (step_l && !step_r) begin
            idx_nxt = (idx == '0) ? IDX_TOP : idx - IDX_W'(1);
        end
    end

    always_ff @(posedge CLK_in or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else begin
            idx <= idx_nxt;
        end
    end

    assign i = {24'h0, 2'b00, idx, 2'b00};

endmodule

// File: tb/tb_button_nav.sv
// Randomised and directed bench for button_nav against a run-length model of
// the debouncers plus a modular-arithmetic model of the browse index.
module tb_button_nav;

    localparam int unsigned DM = 4;
    localparam int unsigned IM = 9;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  raw   = '0;
    logic [4:0]  btn_level;
    logic [4:0]  btn_pulse;
    logic [3:0]  idx;
    logic [31:0] i;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    button_nav #(
        .DEBOUNCE_MAX(DM),
        .IDX_MAX     (IM)
    ) dut (
        .CLK_in       (clk),
        .reset        (rst_n),
        .button_up    (raw[0]),
        .button_down  (raw[1]),
        .button_left  (raw[2]),
        .button_right (raw[3]),
        .button_middle(raw[4]),
        .btn_level    (btn_level),
        .btn_pulse    (btn_pulse),
        .idx          (idx),
        .i            (i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a button flips its level once the synchronised input has
    // disagreed with it for DM+1 consecutive samples; rising flips pulse.
    int m_run[5];
    bit m_d1[5];
    bit m_d2[5];
    bit m_lvl[5];
    bit m_pls[5];
    int m_idx = 0;

    task automatic model_clear();
        for (int b = 0; b < 5; b++) begin
            m_run[b] = 0; m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_pls[b] = 0;
        end
        m_idx = 0;
    endtask

    task automatic model_step();
        bit s;
        if (m_pls[3] && !m_pls[2])      m_idx = (m_idx + 1) % (IM + 1);
        else if (m_pls[2] && !m_pls[3]) m_idx = (m_idx + IM) % (IM + 1);
        for (int b = 0; b < 5; b++) begin
            s        = m_d2[b];
            m_d2[b]  = m_d1[b];
            m_d1[b]  = raw[b];
            m_pls[b] = 1'b0;
            if (s != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == int'(DM) + 1) begin
                    m_lvl[b] = s;
                    m_pls[b] = s;
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else        model_step();
        end
    end

    initial begin
        logic [4:0] ml;
        logic [4:0] mp;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                for (int b = 0; b < 5; b++) begin
                    ml[b] = m_lvl[b];
                    mp[b] = m_pls[b];
                end
                check("model_level", 32'(btn_level), 32'(ml));
                check("model_pulse", 32'(btn_pulse), 32'(mp));
                check("model_idx",   32'(idx),       32'(m_idx));
                check("model_i",     i,              32'(m_idx * 4));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Edges counted from 0 = first rising edge after the stimulus negedge.
    task automatic measure(input int ba, input int bb, input int n,
                           output int fa, output int ca, output int fb, output int cb);
        fa = -1; ca = 0; fb = -1; cb = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (btn_pulse[ba]) begin ca++; if (fa < 0) fa = c; end
            if (btn_pulse[bb]) begin cb++; if (fb < 0) fb = c; end
        end
    endtask

    task automatic press_right(input int hold);
        int fa, ca, fb, cb;
        @(negedge clk);
        raw[3] = 1'b1;
        measure(3, 3, hold, fa, ca, fb, cb);
        check("press_count", 32'(ca), 32'd1);
        @(negedge clk);
        raw[3] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int fa, ca, fb, cb;
        int hold[5];

        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_pulse", 32'(btn_pulse), 32'd0);
        check("rst_idx",   32'(idx),       32'd0);
        check("rst_i",     i,              32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean press of right.
        @(negedge clk);
        raw[3] = 1'b1;
        measure(3, 3, 20, fa, ca, fb, cb);
        check("clean_first", 32'(fa), 32'd6);
        check("clean_count", 32'(ca), 32'd1);
        check("clean_idx",   32'(idx), 32'd1);
        check("clean_i",     i, 32'h4);
        check("clean_level", 32'(btn_level[3]), 32'd1);
        @(negedge clk);
        raw[3] = 1'b0;
        repeat (10) @(negedge clk);

        // Bouncing left, then a stable hold.
        do_reset();
        @(negedge clk);
        raw[2] = 1'b1; repeat (2) @(negedge clk);
        raw[2] = 1'b0; repeat (2) @(negedge clk);
        raw[2] = 1'b1; repeat (2) @(negedge clk);
        raw[2] = 1'b0; repeat (2) @(negedge clk);
        raw[2] = 1'b1;
        measure(2, 2, 20, fa, ca, fb, cb);
        check("bounce_first", 32'(fa), 32'd6);
        check("bounce_count", 32'(ca), 32'd1);
        check("bounce_idx",   32'(idx), 32'd9);
        check("bounce_i",     i, 32'h24);
        @(negedge clk);
        raw[2] = 1'b0;
        repeat (10) @(negedge clk);

        // Ten long right presses wrap 9 -> 0.
        do_reset();
        for (int p = 0; p < 10; p++) begin
            press_right(50);
            check("wrap_idx", 32'(idx), 32'((p + 1) % 10));
        end

        // Simultaneous left and right at idx 5.
        for (int p = 0; p < 5; p++) press_right(10);
        check("simul_pre_idx", 32'(idx), 32'd5);
        @(negedge clk);
        raw[2] = 1'b1;
        raw[3] = 1'b1;
        measure(2, 3, 20, fa, ca, fb, cb);
        check("simul_left_first",  32'(fa), 32'd6);
        check("simul_right_first", 32'(fb), 32'd6);
        check("simul_idx",         32'(idx), 32'd5);
        @(negedge clk);
        raw[2] = 1'b0;
        raw[3] = 1'b0;
        repeat (10) @(negedge clk);

        // Reset while right is partway through qualification.
        raw[3] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_idx",   32'(idx), 32'd0);
        check("midrst_i",     i, 32'd0);
        check("midrst_level", 32'(btn_level), 32'd0);
        check("midrst_pulse", 32'(btn_pulse), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        measure(3, 3, 20, fa, ca, fb, cb);
        check("midrst_first", 32'(fa), 32'd6);
        check("midrst_count", 32'(ca), 32'd1);
        check("midrst_idx_after", 32'(idx), 32'd1);
        @(negedge clk);
        raw[3] = 1'b0;
        repeat (10) @(negedge clk);

        // Release filter on up.
        do_reset();
        @(negedge clk);
        raw[0] = 1'b1;
        measure(0, 0, 10, fa, ca, fb, cb);
        check("relf_press_count", 32'(ca), 32'd1);
        @(negedge clk);
        raw[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        raw[0] = 1'b1;
        measure(0, 0, 15, fa, ca, fb, cb);
        check("relf_no_repulse", 32'(ca), 32'd0);
        check("relf_level_held", 32'(btn_level[0]), 32'd1);
        @(negedge clk);
        raw[0] = 1'b0;
        measure(0, 0, 6, fa, ca, fb, cb);
        check("relf_level_before", 32'(btn_level[0]), 32'd1);
        @(posedge clk);
        #1;
        check("relf_level_after", 32'(btn_level[0]), 32'd0);
        repeat (5) @(negedge clk);

        // Randomised mix of bounces and holds with occasional resets.
        do_reset();
        for (int b = 0; b < 5; b++) hold[b] = int'($urandom_range(1, 20));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 700 == 350) rst_n = 1'b0;
            if (cyc % 700 == 352) rst_n = 1'b1;
            for (int b = 0; b < 5; b++) begin
                if (hold[b] == 0) begin
                    raw[b]  = ~raw[b];
                    hold[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(10, 40))
                                                          : int'($urandom_range(1, 7));
                end else begin
                    hold[b]--;
                end
            end
        end
        raw = '0;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
